// File: rtl/return_stack_if.sv
// Push/pop strobe bundle between the control unit and the return-address stack.
// The control side (master) drives the strobes; the stack (slave) returns its state.
interface return_stack_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = 4
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0] ret_addr;
  logic [PTR_WIDTH:0]    count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, push_addr,
    input  ret_addr, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_addr,
    output ret_addr, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_stack.sv
// Hardware return-address stack: LIFO of return addresses with saturating
// occupancy, full/empty flags and sticky overflow/underflow error flags.
module return_stack #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic clk,
  input  logic rst,
  return_stack_if.slave bus
);
  localparam logic [PTR_WIDTH:0] SP_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0] SP_FULL = (PTR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH:0]    sp_reg, sp_next;
  logic                  overflow_reg, overflow_next;
  logic                  underflow_reg, underflow_next;
  logic                  wr_en;
  logic [PTR_WIDTH-1:0]  wr_idx;
  logic [PTR_WIDTH:0]    sp_dec;
  logic [PTR_WIDTH-1:0]  top_idx;
  logic                  is_empty, is_full;

  assign is_empty = (sp_reg == '0);
  assign is_full  = (sp_reg == SP_FULL);
  assign sp_dec   = sp_reg - SP_ONE;
  assign top_idx  = sp_dec[PTR_WIDTH-1:0];

  always_comb begin
    sp_next        = sp_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    wr_en          = 1'b0;
    wr_idx         = sp_reg[PTR_WIDTH-1:0];
    unique case ({bus.push, bus.pop})
      2'b11: begin
        // Simultaneous push+pop replaces the top; on empty it degrades to a plain push.
        wr_en = 1'b1;
        if (is_empty) begin
          wr_idx  = '0;
          sp_next = SP_ONE;
        end else begin
          wr_idx  = top_idx;
        end
      end
      2'b10: begin
        if (is_full) begin
          overflow_next = 1'b1;
        end else begin
          wr_en   = 1'b1;
          sp_next = sp_reg + SP_ONE;
        end
      end
      2'b01: begin
        if (is_empty) begin
          underflow_next = 1'b1;
        end else begin
          sp_next = sp_dec;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      sp_reg        <= sp_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage is never cleared; reset only suppresses the write on its edge.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[wr_idx] <= bus.push_addr;
    end
  end

  assign bus.ret_addr  = is_empty ? '0 : mem[top_idx];
  assign bus.count     = sp_reg;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
endmodule
